mmc_msg_trigger: RTL and testbench

Sits directly downstream of mmc_msg_capture and consumes its 48-bit msg_packet / msg_valid stream. Each packet is checked for framing and CRC7, then compared against a programmable value/mask. After a programmable number of qualifying matches and a programmable delay, the block emits a trigger pulse to the capture/glitch logic. It also keeps CRC-error statistics for debug.

---
 rtl/mmc_msg_trigger.sv | 187 ++++++++++++++++++
 tb/tb_mmc_msg_trigger.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_msg_trigger.sv
// Packet trigger downstream of mmc_msg_capture: framing/CRC7 check, value/mask
// match, match skipping, programmable delay and a fixed-length trigger pulse.
module mmc_msg_trigger #(
    parameter int CNT_WIDTH   = 16,
    parameter int DELAY_WIDTH = 16,
    parameter int TRIG_LEN    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [47:0]            msg_packet,
    input  logic                   msg_valid,
    input  logic                   arm_i,
    input  logic                   disarm_i,
    input  logic [47:0]            match_value,
    input  logic [47:0]            match_mask,
    input  logic                   crc_check_en,
    input  logic [CNT_WIDTH-1:0]   match_count,
    input  logic [DELAY_WIDTH-1:0] trig_delay,
    output logic                   trig_out,
    output logic                   armed,
    output logic                   crc_err,
    output logic [15:0]            crc_err_cnt,
    output logic [5:0]             last_cmd_idx,
    output logic [1:0]             debug_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_FIRE  = 2'd3
    } state_e;

    localparam int FIRE_W = (TRIG_LEN > 1) ? $clog2(TRIG_LEN) : 1;
    localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(TRIG_LEN - 1);

    // CRC7 x^7+x^3+1, zero init, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = data[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    logic [47:0] bit_miss;
    logic        frame_ok;
    logic        crc_exempt;
    logic        crc_ok;
    logic        hit;

    genvar gi;
    generate
        for (gi = 0; gi < 48; gi++) begin : g_cmp
            assign bit_miss[gi] = match_mask[gi] & (msg_packet[gi] ^ match_value[gi]);
        end
    endgenerate

    assign frame_ok   = ~msg_packet[47] & msg_packet[0];
    assign crc_exempt = ~msg_packet[46] & (msg_packet[45:40] == 6'h3F);
    assign crc_ok     = crc_exempt | (crc7(msg_packet[47:8]) == msg_packet[7:1]);
    assign hit        = frame_ok & (crc_ok | ~crc_check_en) & ~(|bit_miss);

    // Stage 1: per-packet evaluation, one packet per cycle with no back-pressure
    logic       s1_hit_q;
    logic       s1_bad_q;
    logic       s1_frame_q;
    logic [5:0] s1_idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hit_q   <= 1'b0;
            s1_bad_q   <= 1'b0;
            s1_frame_q <= 1'b0;
            s1_idx_q   <= '0;
        end else begin
            s1_hit_q   <= msg_valid & hit;
            s1_bad_q   <= msg_valid & frame_ok & ~crc_ok;
            s1_frame_q <= msg_valid & frame_ok;
            s1_idx_q   <= msg_packet[45:40];
        end
    end

    // Stage 2: statistics, independent of the FSM state
    logic        crc_err_q;
    logic [15:0] crc_err_cnt_q;
    logic [5:0]  last_idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_err_q     <= 1'b0;
            crc_err_cnt_q <= '0;
            last_idx_q    <= '0;
        end else begin
            crc_err_q <= s1_bad_q;
            if (s1_bad_q && (crc_err_cnt_q != 16'hFFFF))
                crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
            if (s1_frame_q)
                last_idx_q <= s1_idx_q;
        end
    end

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   skip_q, skip_d;
    logic [CNT_WIDTH-1:0]   limit_q, limit_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [FIRE_W-1:0]      fire_q, fire_d;
    logic                   trig_q, trig_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
            limit_q <= '0;
            delay_q <= '0;
            fire_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            limit_q <= limit_d;
            delay_q <= delay_d;
            fire_q  <= fire_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        limit_d = limit_q;
        delay_d = delay_q;
        fire_d  = fire_q;
        if (disarm_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_d = ST_ARMED;
                        skip_d  = '0;
                        limit_d = match_count;
                    end
                end
                ST_ARMED: begin
                    if (s1_hit_q) begin
                        if (skip_q == limit_q) begin
                            state_d = ST_DELAY;
                            delay_d = trig_delay;
                        end else begin
                            skip_d = skip_q + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_q == '0) begin
                        state_d = ST_FIRE;
                        fire_d  = '0;
                    end else begin
                        delay_d = delay_q - DELAY_WIDTH'(1);
                    end
                end
                ST_FIRE: begin
                    if (fire_q == FIRE_LAST)
                        state_d = ST_IDLE;
                    else
                        fire_d = fire_q + FIRE_W'(1);
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // trig_out is registered alongside the state so it tracks FIRE exactly
        trig_d = (state_d == ST_FIRE);
    end

    assign trig_out     = trig_q;
    assign armed        = (state_q == ST_ARMED) | (state_q == ST_DELAY);
    assign crc_err      = crc_err_q;
    assign crc_err_cnt  = crc_err_cnt_q;
    assign last_cmd_idx = last_idx_q;
    assign debug_state  = state_q;

endmodule

// File: tb/tb_mmc_msg_trigger.sv
// Bench for mmc_msg_trigger: directed scenarios plus random traffic checked
// every cycle against a timeline-based reference model.
module tb_mmc_msg_trigger;

    localparam int TL = 1;
    localparam logic [47:0] CMD0  = 48'h40_0000_0000_95;
    localparam logic [47:0] CMD17 = 48'h51_0000_0000_55;
    localparam logic [47:0] BAD8  = 48'h48_0000_01AA_89;
    localparam logic [47:0] R3    = 48'h3F_00FF_8000_FF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [47:0] pkt, mval, mmask;
    logic        vld, arm, disarm, crc_en;
    logic [15:0] mcount, tdelay;
    logic        trig_out, armed, crc_err;
    logic [15:0] crc_err_cnt;
    logic [5:0]  last_cmd_idx;
    logic [1:0]  debug_state;

    always #5 clk = ~clk;

    mmc_msg_trigger #(.CNT_WIDTH(16), .DELAY_WIDTH(16), .TRIG_LEN(TL)) dut (
        .clk(clk), .reset_n(reset_n), .msg_packet(pkt), .msg_valid(vld),
        .arm_i(arm), .disarm_i(disarm), .match_value(mval), .match_mask(mmask),
        .crc_check_en(crc_en), .match_count(mcount), .trig_delay(tdelay),
        .trig_out(trig_out), .armed(armed), .crc_err(crc_err),
        .crc_err_cnt(crc_err_cnt), .last_cmd_idx(last_cmd_idx), .debug_state(debug_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC as the remainder of m(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] ref_crc(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v = v ^ (47'h89 << (i - 7));
        return v[6:0];
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc({2'b01, idx, arg}), 1'b1};
    endfunction

    // Model: mode 0 idle, 1 armed, 2 trigger scheduled at absolute cycle m_fire_at
    int          cyc;
    int          m_mode, m_hits, m_lim, m_fire_at;
    logic        p_valid, p_frame, p_crcok, p_hit;
    logic [5:0]  p_idx, e_idx;
    logic        e_err;
    logic [15:0] e_cnt;
    int          trig_seen, trig_first, err_seen;

    task automatic m_reset();
        m_mode = 0; m_hits = 0; m_lim = 0; m_fire_at = 0;
        p_valid = 0; p_frame = 0; p_crcok = 0; p_hit = 0; p_idx = '0;
        e_err = 0; e_cnt = '0; e_idx = '0;
    endtask

    function automatic int m_state();
        if (m_mode == 1) return 1;
        if (m_mode == 2) begin
            if (cyc < m_fire_at) return 2;
            if (cyc < m_fire_at + TL) return 3;
        end
        return 0;
    endfunction

    task automatic step();
        int st;
        @(negedge clk);
        if (m_mode == 2 && cyc >= m_fire_at + TL) m_mode = 0;
        st = m_state();
        chk("trig_out", trig_out, st == 3);
        chk("armed", armed, st == 1 || st == 2);
        chk("debug_state", debug_state, st);
        chk("crc_err", crc_err, e_err);
        chk("crc_err_cnt", crc_err_cnt, e_cnt);
        chk("last_cmd_idx", last_cmd_idx, e_idx);
        if (trig_out) begin
            if (trig_seen == 0) trig_first = cyc;
            trig_seen++;
        end
        if (crc_err) err_seen++;
        if (disarm) m_mode = 0;
        else if (st == 0 && arm) begin m_mode = 1; m_hits = 0; m_lim = mcount; end
        else if (st == 1 && p_hit) begin
            if (m_hits == m_lim) begin m_mode = 2; m_fire_at = cyc + 2 + tdelay; end
            else m_hits++;
        end
        e_err = p_valid && p_frame && !p_crcok;
        if (e_err && e_cnt != 16'hFFFF) e_cnt++;
        if (p_valid && p_frame) e_idx = p_idx;
        p_valid = vld;
        p_frame = !pkt[47] && pkt[0];
        p_crcok = (!pkt[46] && pkt[45:40] == 6'h3F) || (ref_crc(pkt[47:8]) == pkt[7:1]);
        p_hit   = vld && p_frame && (p_crcok || !crc_en) && (((pkt ^ mval) & mmask) == 48'h0);
        p_idx   = pkt[45:40];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cy(input logic v, input logic [47:0] p, input logic a, input logic d);
        vld = v; pkt = p; arm = a; disarm = d;
        step();
        vld = 0; arm = 0; disarm = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cy(1'b0, 48'h0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input logic [47:0] m, input logic [47:0] v, input int c, input int d, input logic e);
        mmask = m; mval = v; mcount = 16'(c); tdelay = 16'(d); crc_en = e;
    endtask

    int c0;
    logic [47:0] rp;

    initial begin
        reset_n = 0; vld = 0; arm = 0; disarm = 0; pkt = '0;
        cfg(48'h0, 48'h0, 0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_trig", trig_out, 0);
        chk("rst_state", debug_state, 0);
        chk("rst_cnt", crc_err_cnt, 0);
        chk("rst_idx", last_cmd_idx, 0);
        reset_n = 1;
        m_reset();
        cyc = 0;
        idle(2);

        // CMD0, no skip, no delay
        cfg(48'hFFFF_FFFF_FF00, 48'h40_0000_0000_00, 0, 0, 1'b1);
        cy(0, 48'h0, 1, 0);
        trig_seen = 0;
        c0 = cyc;
        cy(1, CMD0, 0, 0);
        idle(6);
        chk("s1_latency", trig_first - c0, 3);
        chk("s1_width", trig_seen, 1);
        chk("s1_state", debug_state, 0);
        chk("s1_cnt", crc_err_cnt, 0);
        $display("scenario cmd0 trigger done at cycle %0d", cyc);

        // Index-only match, skip 2, delay 5, CMD0 interleaved
        cfg(48'h3F_0000_0000_00, 48'h51_0000_0000_00, 2, 5, 1'b1);
        cy(0, 48'h0, 1, 0);
        trig_seen = 0;
        cy(1, CMD17, 0, 0); idle(1);
        cy(1, CMD0, 0, 0);  idle(1);
        cy(1, CMD17, 0, 0); idle(2);
        c0 = cyc;
        cy(1, CMD17, 0, 0);
        idle(12);
        chk("s2_latency", trig_first - c0, 8);
        chk("s2_width", trig_seen, 1);
        $display("scenario cmd17 skip/delay done at cycle %0d", cyc);

        // Bad CRC with and without checking
        cfg(48'h0, 48'h0, 0, 0, 1'b1);
        cy(0, 48'h0, 1, 0);
        trig_seen = 0; err_seen = 0;
        cy(1, BAD8, 0, 0);
        idle(6);
        chk("s3_notrig", trig_seen, 0);
        chk("s3_errpulse", err_seen, 1);
        chk("s3_cnt1", crc_err_cnt, 1);
        chk("s3_still_armed", debug_state, 1);
        crc_en = 0;
        cy(1, BAD8, 0, 0);
        idle(6);
        chk("s3_trig", trig_seen, 1);
        chk("s3_cnt2", crc_err_cnt, 2);
        $display("scenario crc check done at cycle %0d", cyc);

        // Framing and R3 exemption
        cfg(48'h0, 48'h0, 0, 0, 1'b1);
        err_seen = 0;
        cy(1, 48'h45_0000_0000_00, 0, 0);
        idle(4);
        chk("s4_noerr", err_seen, 0);
        chk("s4_idx", last_cmd_idx, 6'h08);
        cy(1, R3, 0, 0);
        idle(4);
        chk("s4_r3_noerr", err_seen, 0);
        chk("s4_r3_idx", last_cmd_idx, 6'h3F);
        cy(0, 48'h0, 1, 0);
        trig_seen = 0;
        cy(1, 48'h48_0000_01AA_86, 0, 0);
        idle(6);
        chk("s4_badframe_notrig", trig_seen, 0);
        chk("s4_badframe_armed", debug_state, 1);
        cy(0, 48'h0, 0, 1);
        idle(1);
        $display("scenario framing done at cycle %0d", cyc);

        // Abort during DELAY, then arm+disarm together
        cfg(48'h0, 48'h0, 0, 100, 1'b1);
        cy(0, 48'h0, 1, 0);
        trig_seen = 0;
        cy(1, CMD0, 0, 0);
        idle(10);
        chk("s5_delay", debug_state, 2);
        cy(0, 48'h0, 0, 1);
        idle(120);
        chk("s5_notrig", trig_seen, 0);
        chk("s5_idle", debug_state, 0);
        cy(0, 48'h0, 1, 1);
        idle(2);
        chk("s5_armdisarm", debug_state, 0);
        $display("scenario abort done at cycle %0d", cyc);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0: mmask = 48'h0;
                    1: mmask = 48'h3F_0000_0000_00;
                    default: mmask = 48'hFFFF_FFFF_FF00;
                endcase
                case ($urandom_range(0, 2))
                    0: mval = mk(6'd0, 32'h0);
                    1: mval = mk(6'd8, 32'h0);
                    default: mval = mk(6'd17, 32'h0);
                endcase
                mcount = 16'($urandom_range(0, 3));
                tdelay = 16'($urandom_range(0, 7));
                crc_en = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 5))
                0: rp = mk(6'd0, 32'h0);
                1: rp = mk(6'd17, ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom);
                2: rp = mk(6'($urandom), $urandom);
                3: begin rp = mk(6'd8, 32'h0); rp[3] = ~rp[3]; end
                4: begin rp = mk(6'($urandom), $urandom); rp[0] = 1'b0; end
                default: rp = R3;
            endcase
            cy(1'($urandom_range(0, 1)), rp, $urandom_range(0, 19) == 0,
               $urandom_range(0, 199) == 0);
        end
        idle(12);
        $display("random phase done at cycle %0d", cyc);

        // Asynchronous reset while trig_out is high
        cfg(48'h0, 48'h0, 0, 0, 1'b1);
        cy(0, 48'h0, 0, 1);
        cy(0, 48'h0, 1, 0);
        cy(1, BAD8, 0, 0);
        cy(1, CMD0, 0, 0);
        idle(2);
        chk("s6_pre_trig", trig_out, 1);
        chk("s6_pre_cnt_nonzero", crc_err_cnt != 16'h0, 1);
        reset_n = 0;
        #1;
        chk("s6_async_trig", trig_out, 0);
        chk("s6_async_cnt", crc_err_cnt, 0);
        chk("s6_async_state", debug_state, 0);
        chk("s6_async_idx", last_cmd_idx, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        m_reset();
        idle(2);
        $display("scenario async reset done at cycle %0d", cyc);

        // CRC error counter saturation
        crc_en = 1;
        repeat (65540) cy(1, BAD8, 0, 0);
        idle(3);
        chk("s7_saturate", crc_err_cnt, 16'hFFFF);
        $display("scenario saturation done at cycle %0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
